// File: rtl/rob_multi_commit.sv
// Reorder buffer with N writeback channels and up to two in-order commits per cycle.
// Tags are 1-based (entry k carries tag k+1, tag 0 means none). Operand queries can
// forward results from the writeback channels in the same cycle.
module rob_multi_commit #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned N_WB     = 2,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned PRESERVE = 2,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned REG_W    = 5,
  localparam int unsigned ID_W    = $clog2(DEPTH) + 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     alloc_valid,
  input  logic [REG_W-1:0]         alloc_rd,
  input  logic [XLEN-1:0]          alloc_pc,
  input  logic                     alloc_is_br,
  input  logic                     alloc_is_st,
  input  logic                     alloc_pred_taken,
  input  logic [XLEN-1:0]          alloc_fallthru,
  output logic [ID_W-1:0]          alloc_id,
  output logic                     alloc_ready,
  output logic                     empty,
  input  logic [2*ID_W-1:0]        q_id,
  output logic [1:0]               q_ready,
  output logic [2*XLEN-1:0]        q_data,
  input  logic [N_WB-1:0]          wb_valid,
  input  logic [N_WB*ID_W-1:0]     wb_id,
  input  logic [N_WB*XLEN-1:0]     wb_data,
  input  logic [N_WB-1:0]          wb_taken,
  input  logic [N_WB*XLEN-1:0]     wb_target,
  output logic [COMMIT_W-1:0]      cm_valid,
  output logic [COMMIT_W*REG_W-1:0] cm_rd,
  output logic [COMMIT_W*XLEN-1:0] cm_data,
  output logic [COMMIT_W*ID_W-1:0] cm_id,
  output logic                     pred_en,
  output logic [XLEN-1:0]          pred_pc,
  output logic                     pred_taken,
  output logic                     rollback_o,
  output logic [XLEN-1:0]          rollback_pc
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [ID_W-1:0]  DEPTH_ID = ID_W'(DEPTH);
  localparam logic [ID_W-1:0]  ONE_ID   = ID_W'(1);
  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(DEPTH - PRESERVE);

  typedef struct packed {
    logic             busy;
    logic             ready;
    logic             is_br;
    logic             is_st;
    logic             pred;
    logic             taken;
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  fallthru;
    logic [XLEN-1:0]  data;
    logic [XLEN-1:0]  target;
  } entry_t;

  entry_t ent_q [DEPTH];
  entry_t ent_d [DEPTH];

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [COMMIT_W-1:0]       cm_valid_q, cm_valid_d;
  logic [COMMIT_W*REG_W-1:0] cm_rd_q, cm_rd_d;
  logic [COMMIT_W*XLEN-1:0]  cm_data_q, cm_data_d;
  logic [COMMIT_W*ID_W-1:0]  cm_id_q, cm_id_d;
  logic                      pred_en_q, pred_en_d;
  logic [XLEN-1:0]           pred_pc_q, pred_pc_d;
  logic                      pred_taken_q, pred_taken_d;
  logic                      rollback_q, rollback_d;
  logic [XLEN-1:0]           rollback_pc_q, rollback_pc_d;

  logic alloc_acc;

  // Combinational status outputs derived from occupancy and the flush pulse.
  always_comb begin
    alloc_id    = {1'b0, tail_q} + ONE_ID;
    alloc_ready = (count_q < LIMIT) && !rollback_q;
    empty       = (count_q == '0);
    alloc_acc   = alloc_valid && alloc_ready;
  end

  // Operand queries: stored result first, otherwise forward from this cycle's writebacks.
  always_comb begin
    logic [ID_W-1:0]  qtag;
    logic [IDX_W-1:0] qidx;
    q_ready = '0;
    q_data  = '0;
    for (int k = 0; k < 2; k++) begin
      qtag = q_id[k*ID_W +: ID_W];
      qidx = IDX_W'(qtag - ONE_ID);
      if (qtag != '0 && qtag <= DEPTH_ID && ent_q[qidx].busy) begin
        if (ent_q[qidx].ready) begin
          q_ready[k]             = 1'b1;
          q_data[k*XLEN +: XLEN] = ent_q[qidx].data;
        end else begin
          // Ascending scan so the highest matching channel wins, as in writeback.
          for (int c = 0; c < N_WB; c++) begin
            if (wb_valid[c] && wb_id[c*ID_W +: ID_W] == qtag) begin
              q_ready[k]             = 1'b1;
              q_data[k*XLEN +: XLEN] = wb_data[c*XLEN +: XLEN];
            end
          end
        end
      end
    end
  end

  // Next-state: writeback, commit, allocate, then mispredict flush overrides all.
  always_comb begin
    logic [ID_W-1:0]  wtag;
    logic [IDX_W-1:0] widx;
    logic [IDX_W-1:0] lidx;
    logic [IDX_W-1:0] br_idx;
    logic             go;
    logic             br_hit;
    logic             mispred;
    logic [CNT_W-1:0] ncm;

    ent_d         = ent_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    cm_valid_d    = cm_valid_q;
    cm_rd_d       = cm_rd_q;
    cm_data_d     = cm_data_q;
    cm_id_d       = cm_id_q;
    pred_en_d     = pred_en_q;
    pred_pc_d     = pred_pc_q;
    pred_taken_d  = pred_taken_q;
    rollback_d    = rollback_q;
    rollback_pc_d = rollback_pc_q;
    wtag          = '0;
    widx          = '0;
    lidx          = '0;
    br_idx        = '0;
    go            = 1'b1;
    br_hit        = 1'b0;
    mispred       = 1'b0;
    ncm           = '0;

    if (rdy_in) begin
      cm_valid_d = '0;
      pred_en_d  = 1'b0;
      rollback_d = 1'b0;

      if (!rollback_q) begin
        for (int c = 0; c < N_WB; c++) begin
          wtag = wb_id[c*ID_W +: ID_W];
          widx = IDX_W'(wtag - ONE_ID);
          if (wb_valid[c] && wtag != '0 && wtag <= DEPTH_ID && ent_q[widx].busy) begin
            ent_d[widx].ready  = 1'b1;
            ent_d[widx].data   = wb_data[c*XLEN +: XLEN];
            ent_d[widx].taken  = wb_taken[c];
            ent_d[widx].target = wb_target[c*XLEN +: XLEN];
          end
        end
      end

      // Lanes chain: a lane commits only if the previous one did and was not a branch.
      for (int l = 0; l < COMMIT_W; l++) begin
        lidx = head_q + IDX_W'(l);
        if (go && ent_q[lidx].busy && (ent_q[lidx].ready || ent_q[lidx].is_st)) begin
          cm_valid_d[l]               = 1'b1;
          cm_rd_d[l*REG_W +: REG_W]   = ent_q[lidx].rd;
          cm_data_d[l*XLEN +: XLEN]   = ent_q[lidx].data;
          cm_id_d[l*ID_W +: ID_W]     = {1'b0, lidx} + ONE_ID;
          ent_d[lidx]                 = '0;
          ncm                         = ncm + CNT_W'(1);
          if (ent_q[lidx].is_br) begin
            br_hit = 1'b1;
            br_idx = lidx;
            go     = 1'b0;
          end
        end else begin
          go = 1'b0;
        end
      end
      head_d = head_q + IDX_W'(ncm);

      if (br_hit) begin
        pred_en_d    = 1'b1;
        pred_pc_d    = ent_q[br_idx].pc;
        pred_taken_d = ent_q[br_idx].taken;
        if (ent_q[br_idx].pred != ent_q[br_idx].taken) begin
          mispred       = 1'b1;
          rollback_d    = 1'b1;
          rollback_pc_d = ent_q[br_idx].taken ? ent_q[br_idx].target : ent_q[br_idx].fallthru;
        end
      end

      if (alloc_acc) begin
        ent_d[tail_q].busy     = 1'b1;
        ent_d[tail_q].ready    = 1'b0;
        ent_d[tail_q].is_br    = alloc_is_br;
        ent_d[tail_q].is_st    = alloc_is_st;
        ent_d[tail_q].pred     = alloc_pred_taken;
        ent_d[tail_q].taken    = 1'b0;
        ent_d[tail_q].rd       = alloc_rd;
        ent_d[tail_q].pc       = alloc_pc;
        ent_d[tail_q].fallthru = alloc_fallthru;
        ent_d[tail_q].data     = '0;
        ent_d[tail_q].target   = '0;
        tail_d                 = tail_q + IDX_W'(1);
      end
      count_d = count_q + CNT_W'(alloc_acc) - ncm;

      if (mispred) begin
        for (int i = 0; i < DEPTH; i++) begin
          ent_d[i] = '0;
        end
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  // State and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ent_q         <= '{default: '0};
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      cm_valid_q    <= '0;
      cm_rd_q       <= '0;
      cm_data_q     <= '0;
      cm_id_q       <= '0;
      pred_en_q     <= 1'b0;
      pred_pc_q     <= '0;
      pred_taken_q  <= 1'b0;
      rollback_q    <= 1'b0;
      rollback_pc_q <= '0;
    end else begin
      ent_q         <= ent_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      cm_valid_q    <= cm_valid_d;
      cm_rd_q       <= cm_rd_d;
      cm_data_q     <= cm_data_d;
      cm_id_q       <= cm_id_d;
      pred_en_q     <= pred_en_d;
      pred_pc_q     <= pred_pc_d;
      pred_taken_q  <= pred_taken_d;
      rollback_q    <= rollback_d;
      rollback_pc_q <= rollback_pc_d;
    end
  end

  assign cm_valid    = cm_valid_q;
  assign cm_rd       = cm_rd_q;
  assign cm_data     = cm_data_q;
  assign cm_id       = cm_id_q;
  assign pred_en     = pred_en_q;
  assign pred_pc     = pred_pc_q;
  assign pred_taken  = pred_taken_q;
  assign rollback_o  = rollback_q;
  assign rollback_pc = rollback_pc_q;

endmodule
